// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer, synchronous flush and
// MIPS field slicing of the held instruction.
//
// state | meaning
// EMPTY | no instruction held (m_valid=0, s_valid=0)
// FULL  | main register holds the oldest instruction, skid free
// SKID  | main and skid both hold; skid is the younger one, in_ready=0
module ifid_skid_stage #(
  parameter int PC_WIDTH    = 9,
  parameter int INSTR_WIDTH = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [15:0]            imm16,
  output logic [25:0]            address_26
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic                   m_valid_q, m_valid_d;
  logic                   s_valid_q, s_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [INSTR_WIDTH-1:0] m_instr_q, m_instr_d;
  logic [INSTR_WIDTH-1:0] s_instr_q, s_instr_d;
  logic [PC_WIDTH-1:0]    m_pc_q, m_pc_d;
  logic [PC_WIDTH-1:0]    s_pc_q, s_pc_d;
  logic                   accept;
  logic                   drain;
  logic                   bubble;

  assign accept = in_valid & in_ready_q;
  assign drain  = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    if (flush) begin
      // data registers keep their contents; only the valid bits are squashed
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      case ({m_valid_q, s_valid_q})
        ST_EMPTY: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_instr_d = in_instr;
            s_pc_d    = in_pc;
          end else if (drain) begin
            m_valid_d = 1'b0;
          end
        end
        ST_SKID: begin
          if (drain) begin
            s_valid_d = 1'b0;
            m_instr_d = s_instr_q;
            m_pc_d    = s_pc_q;
          end
        end
        default: begin
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
        end
      endcase
    end
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      m_instr_q  <= '0;
      m_pc_q     <= '0;
      s_instr_q  <= '0;
      s_pc_q     <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
      m_instr_q  <= m_instr_d;
      m_pc_q     <= m_pc_d;
      s_instr_q  <= s_instr_d;
      s_pc_q     <= s_pc_d;
    end
  end

  assign bubble    = ZERO_BUBBLE & ~m_valid_q;
  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_instr = bubble ? '0 : m_instr_q;
  assign out_pc    = bubble ? '0 : m_pc_q;

  assign opcode     = out_instr[31:26];
  assign rs         = out_instr[25:21];
  assign rt         = out_instr[20:16];
  assign rd         = out_instr[15:11];
  assign shamt      = out_instr[10:6];
  assign funct      = out_instr[5:0];
  assign imm16      = out_instr[15:0];
  assign address_26 = out_instr[25:0];

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage; a ZERO_BUBBLE=0 copy shares the stimulus
// so the hold-last-value behaviour can be checked alongside the default build.
module tb_ifid_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [8:0]  in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] address_26;

  logic        z_in_ready, z_out_valid;
  logic [31:0] z_out_instr;
  logic [8:0]  z_out_pc;
  logic [5:0]  z_opcode, z_funct;
  logic [4:0]  z_rs, z_rt, z_rd, z_shamt;
  logic [15:0] z_imm16;
  logic [25:0] z_address_26;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADDI = 32'h2408_0005;
  localparam logic [31:0] I_ADDU = 32'h0109_5021;
  localparam logic [31:0] I_A    = 32'h0C00_0010;
  localparam logic [31:0] I_B    = 32'h1000_FFFF;
  localparam logic [31:0] I_C    = 32'h2009_0007;
  localparam logic [31:0] I_D    = 32'h0000_0020;
  localparam logic [31:0] I_E    = 32'h3C01_1234;
  localparam logic [31:0] I_F    = 32'h2402_0003;

  ifid_skid_stage #(.PC_WIDTH(9), .INSTR_WIDTH(32), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .address_26(address_26)
  );

  ifid_skid_stage #(.PC_WIDTH(9), .INSTR_WIDTH(32), .ZERO_BUBBLE(1'b0)) dut_zb0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_instr(z_out_instr), .out_pc(z_out_pc),
    .opcode(z_opcode), .rs(z_rs), .rt(z_rt), .rd(z_rd), .shamt(z_shamt),
    .funct(z_funct), .imm16(z_imm16), .address_26(z_address_26)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [8:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, I_ADDI, 9'd4);

    // reset held for two edges with a valid input
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_opcode",    32'(opcode), 32'd0);
    check("rst_out_pc",    32'(out_pc), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // streaming
    reset = 1'b1;
    tick();
    check("s1_out_valid", 32'(out_valid), 32'd1);
    check("s1_opcode",    32'(opcode), 32'h09);
    check("s1_rs",        32'(rs), 32'd0);
    check("s1_rt",        32'(rt), 32'd8);
    check("s1_imm16",     32'(imm16), 32'd5);
    check("s1_out_pc",    32'(out_pc), 32'd4);
    check("s1_in_ready",  32'(in_ready), 32'd1);
    drive(1'b1, I_ADDU, 9'd8);
    tick();
    check("s2_funct",     32'(funct), 32'h21);
    check("s2_rd",        32'(rd), 32'd10);
    check("s2_rs",        32'(rs), 32'd8);
    check("s2_rt",        32'(rt), 32'd9);
    check("s2_shamt",     32'(shamt), 32'd0);
    check("s2_out_pc",    32'(out_pc), 32'd8);
    check("s2_in_ready",  32'(in_ready), 32'd1);
    drive(1'b0, 32'd0, 9'd0);
    tick();
    check("s3_out_valid", 32'(out_valid), 32'd0);
    check("s3_bubble",    out_instr, 32'd0);
    check("s3_zb0_hold",  z_out_instr, I_ADDU);
    check("s3_zb0_pc",    32'(z_out_pc), 32'd8);

    // back-pressure into the skid entry
    out_ready = 1'b0;
    drive(1'b1, I_A, 9'd12);
    tick();
    check("bp_a_instr",   out_instr, I_A);
    check("bp_a_addr26",  32'(address_26), 32'h10);
    check("bp_a_ready",   32'(in_ready), 32'd1);
    drive(1'b1, I_B, 9'd16);
    tick();
    check("bp_b_ready",   32'(in_ready), 32'd0);
    check("bp_b_head",    out_instr, I_A);
    drive(1'b1, I_C, 9'd20);
    tick();
    check("bp_c_stall",   32'(in_ready), 32'd0);
    check("bp_c_head",    out_instr, I_A);
    out_ready = 1'b1;
    tick();
    check("bp_drain_b",   out_instr, I_B);
    check("bp_drain_pc",  32'(out_pc), 32'd16);
    check("bp_drain_rdy", 32'(in_ready), 32'd1);
    tick();
    check("bp_drain_c",   out_instr, I_C);
    check("bp_c_pc",      32'(out_pc), 32'd20);
    drive(1'b0, 32'd0, 9'd0);
    tick();
    check("bp_empty",     32'(out_valid), 32'd0);

    // flush while in SKID, with an incoming instruction
    out_ready = 1'b0;
    drive(1'b1, I_A, 9'd12);
    tick();
    drive(1'b1, I_B, 9'd16);
    tick();
    check("fs_skid_rdy",  32'(in_ready), 32'd0);
    drive(1'b1, I_E, 9'd24);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fs_out_valid", 32'(out_valid), 32'd0);
    check("fs_out_instr", out_instr, 32'd0);
    check("fs_in_ready",  32'(in_ready), 32'd1);
    drive(1'b0, 32'd0, 9'd0);
    tick();
    check("fs_e_lost",    32'(out_valid), 32'd0);
    drive(1'b1, I_F, 9'd28);
    tick();
    check("fs_f_valid",   32'(out_valid), 32'd1);
    check("fs_f_instr",   out_instr, I_F);
    check("fs_f_pc",      32'(out_pc), 32'd28);
    drive(1'b0, 32'd0, 9'd0);
    out_ready = 1'b1;
    tick();
    check("fs_f_drained", 32'(out_valid), 32'd0);

    // flush coinciding with a drain of A; D is discarded
    out_ready = 1'b0;
    drive(1'b1, I_A, 9'd12);
    tick();
    check("fd_full",      out_instr, I_A);
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(1'b1, I_D, 9'd32);
    tick();
    flush = 1'b0;
    check("fd_out_valid", 32'(out_valid), 32'd0);
    check("fd_in_ready",  32'(in_ready), 32'd1);
    check("fd_zb0_keep",  z_out_instr, I_A);
    drive(1'b0, 32'd0, 9'd0);
    tick();
    check("fd_still_emp", 32'(out_valid), 32'd0);

    // ZERO_BUBBLE=0: drained A remains visible on the data outputs
    drive(1'b1, I_A, 9'd12);
    tick();
    drive(1'b0, 32'd0, 9'd0);
    tick();
    check("zb0_valid",    32'(z_out_valid), 32'd0);
    check("zb0_instr",    z_out_instr, I_A);
    check("zb1_instr",    out_instr, 32'd0);

    // reset while in SKID discards both entries
    out_ready = 1'b0;
    drive(1'b1, I_A, 9'd12);
    tick();
    drive(1'b1, I_B, 9'd16);
    tick();
    drive(1'b1, I_C, 9'd20);
    reset = 1'b0;
    tick();
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready",  32'(in_ready), 32'd1);
    check("mr_zb0_instr", z_out_instr, 32'd0);
    reset = 1'b1;
    drive(1'b0, 32'd0, 9'd0);
    out_ready = 1'b1;
    tick();
    check("mr_no_skid",   32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised successor to the IF/ID pipeline register: carries the fetched instruction and its PC from fetch to decode.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from decode does not need a combinational path to fetch.
- Adds synchronous flush for branch/jump squash and optional bubble zeroing.
- Decoded MIPS fields are slices of the output instruction register, so they remain available to decode at zero extra latency.

Parameters:
- PC_WIDTH, 9: width of the PC carried through the stage.
- INSTR_WIDTH, 32: instruction width. Must be 32; field slicing assumes the MIPS layout.
- ZERO_BUBBLE, 1: when 1, out_instr and out_pc read 0 (NOP) while out_valid=0. When 0, they hold their last value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; asserted when 0 at a rising edge of clk.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_instr  in  INSTR_WIDTH  fetched instruction.
- in_pc  in  PC_WIDTH  PC of the fetched instruction.
- flush  in  1  squash all held and incoming instructions this cycle.
- out_valid  out  1  decode-side instruction valid.
- out_ready  in  1  decode can accept.
- out_instr  out  INSTR_WIDTH  held instruction.
- out_pc  out  PC_WIDTH  held PC.
- opcode  out  6  out_instr[31:26].
- rs  out  5  out_instr[25:21].
- rt  out  5  out_instr[20:16].
- rd  out  5  out_instr[15:11].
- shamt  out  5  out_instr[10:6].
- funct  out  6  out_instr[5:0].
- imm16  out  16  out_instr[15:0].
- address_26  out  26  out_instr[25:0].

Behaviour:
- Storage:
  - main register (m_valid, m_instr, m_pc) drives the outputs.
  - skid register (s_valid, s_instr, s_pc).
- State encoding: EMPTY (m_valid=0, s_valid=0), FULL (m_valid=1, s_valid=0), SKID (m_valid=1, s_valid=1). The combination m_valid=0, s_valid=1 is unreachable.
- Handshake:
  - in_ready = !s_valid, registered.
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - out_valid = m_valid.
  - in_valid may be asserted regardless of in_ready. Data is held by fetch until accepted.
- Transitions, evaluated at each rising edge when reset=1 and flush=0:
  - EMPTY + accept -> FULL; main loads the input.
  - FULL + accept + drain -> FULL; main loads the input.
  - FULL + accept + !drain -> SKID; skid loads the input, main holds.
  - FULL + !accept + drain -> EMPTY.
  - FULL, no accept, no drain -> FULL; hold.
  - SKID + drain -> FULL; main loads from skid. accept is impossible in SKID because in_ready=0.
  - SKID + !drain -> SKID; hold.
- Latency and throughput:
  - An instruction accepted at edge N is visible on the outputs after edge N (1 cycle).
  - Throughput is 1 instruction per cycle when out_ready=1.
- Ordering: strict FIFO. The skid entry is always older than any later input.
- Flush, at an edge with reset=1 and flush=1:
  - m_valid and s_valid are cleared; state becomes EMPTY.
  - Any accept in the same cycle is discarded.
  - in_ready=1 after the edge.
  - A drain in the flush cycle still counts as consumed by decode, since decode saw a valid instruction that cycle.
- Reset, at an edge with reset=0:
  - all valid bits and all data registers are cleared to 0; in_ready=1.
  - out_valid=0, out_instr=0, out_pc=0, all fields=0.
  - Reset overrides flush and the handshake.
  - Reset mid-stream (including in SKID) discards everything.
- Data registers load only on the transitions above and hold otherwise. They are not cleared by flush.
- ZERO_BUBBLE=1: out_instr and out_pc are gated to 0 when m_valid=0, so the fields decode as NOP (sll $0,$0,0).
- All field outputs are combinational slices of out_instr (after gating). There is no additional register stage.
- No arithmetic is performed; PC is passed through unchanged at PC_WIDTH bits.

Test Plan:
- Reset: hold reset=0 for 2 edges with in_valid=1, in_instr=32'h2408_0005 -> out_valid=0, out_instr=0, opcode=0, in_ready=1. Release reset -> first accepted instruction appears 1 cycle later.
- Streaming: out_ready=1; send 0x2408_0005 (pc=4), then 0x0109_5021 (pc=8) back-to-back -> outputs appear in consecutive cycles.
  - First: opcode=6'h09, rs=0, rt=8, imm16=5.
  - Second: funct=6'h21, rd=10, out_pc=8.
  - in_ready stays 1 throughout.
- Back-pressure: out_ready=0; send A=0x0C00_0010, then B=0x1000_FFFF.
  - in_ready=0 after B is accepted; C is not accepted.
  - Raise out_ready: A, then B, then C emerge in order; address_26 of A = 26'h10.
- Flush in SKID: with A and B held, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_instr=0, in_ready=1. The incoming instruction is lost; the next accepted instruction appears normally.
- Flush with drain: FULL with A, out_ready=1, flush=1, new D presented -> A is consumed that cycle, D is discarded, state becomes EMPTY.
- ZERO_BUBBLE=0 build: after A is drained with no new input -> out_valid=0 and out_instr still reads 0x0C00_0010.
